// File: rtl/lzc_norm_pipe.sv
// Pipelined leading/trailing zero/one counter with normaliser.
// The run length is counted ahead of the first register stage. The normalising
// shift is applied ahead of the second stage when there is one, and ahead of
// the first stage otherwise. Any further stages only add latency. Valid/ready
// flow control allows one beat per cycle, and empty stages collapse.
module lzc_norm_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned USER_W = 4,
  localparam int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [1:0]        i_mode,
  input  logic [USER_W-1:0] i_user,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [CW-1:0]     o_cnt,
  output logic              o_all,
  output logic [WIDTH-1:0]  o_norm,
  output logic [USER_W-1:0] o_user
);

  typedef enum logic [1:0] {
    MODE_LZ = 2'b00,
    MODE_LO = 2'b01,
    MODE_TZ = 2'b10,
    MODE_TO = 2'b11
  } mode_e;

  // Index of the stage whose input receives the shifted data.
  localparam int unsigned SH = (STAGES >= 2) ? 1 : 0;

  // Run length of the selected bit value, counted from the selected end.
  // The ones modes invert the operand and the trailing modes bit-reverse it,
  // so a single leading-zero scan serves all four modes.
  function automatic logic [CW-1:0] run_len(input logic [WIDTH-1:0] d,
                                            input mode_e m);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] r;
    logic             found;
    logic [CW-1:0]    c;
    x = (m == MODE_LO || m == MODE_TO) ? ~d : d;
    for (int unsigned i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    if (m == MODE_TZ || m == MODE_TO) x = r;
    c     = CW'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && x[WIDTH-1-i]) begin
        c     = CW'(i);
        found = 1'b1;
      end
    end
    return c;
  endfunction

  // Leading modes shift left and trailing modes shift right, both with zero
  // fill. A shift of WIDTH clears the word.
  function automatic logic [WIDTH-1:0] normalise(input logic [WIDTH-1:0] d,
                                                 input mode_e m,
                                                 input logic [CW-1:0] c);
    return (m == MODE_TZ || m == MODE_TO) ? (d >> c) : (d << c);
  endfunction

  // Stage registers.
  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] st_all;
  logic [WIDTH-1:0]  st_data [STAGES];
  logic [USER_W-1:0] st_user [STAGES];
  logic [CW-1:0]     st_cnt  [STAGES];

  // Values presented to each stage's input.
  logic [STAGES-1:0] nx_v;
  logic [STAGES-1:0] nx_all;
  logic [WIDTH-1:0]  nx_data [STAGES];
  logic [USER_W-1:0] nx_user [STAGES];
  logic [CW-1:0]     nx_cnt  [STAGES];

  logic [STAGES-1:0] load;
  logic              tail_full;
  logic [CW-1:0]     in_cnt;
  mode_e             sh_mode;
  logic [WIDTH-1:0]  sh_data;
  logic [CW-1:0]     sh_cnt;
  logic [WIDTH-1:0]  sh_norm;

  assign in_cnt  = run_len(i_data, mode_e'(i_mode));
  assign sh_norm = normalise(sh_data, sh_mode, sh_cnt);

  // The mode is needed only until the shift. It gets its own register beside
  // stage 0 instead of travelling down every stage.
  if (SH == 1) begin : g_split
    mode_e mid_mode;

    // Capture the mode together with the beat that enters stage 0.
    always_ff @(posedge clk or negedge rstf) begin
      if (!rstf) begin
        mid_mode <= MODE_LZ;
      end else if (load[0] && i_valid) begin
        mid_mode <= mode_e'(i_mode);
      end
    end

    assign sh_mode = mid_mode;
    assign sh_data = st_data[0];
    assign sh_cnt  = st_cnt[0];
  end else begin : g_flat
    assign sh_mode = mode_e'(i_mode);
    assign sh_data = i_data;
    assign sh_cnt  = in_cnt;
  end

  // A stage loads when it is empty or everything downstream of it can move.
  // That is true when o_ready is high or some stage from here to the output
  // is empty.
  always_comb begin
    load      = '0;
    tail_full = 1'b1;
    for (int unsigned k = STAGES; k > 0; k--) begin
      tail_full = tail_full & st_v[k-1];
      load[k-1] = o_ready | ~tail_full;
    end
  end

  assign i_ready = load[0];

  // Build each stage's input: counting ahead of stage 0, shifting ahead of stage SH.
  always_comb begin
    nx_v[0]    = i_valid;
    nx_user[0] = i_user;
    nx_cnt[0]  = in_cnt;
    nx_all[0]  = (in_cnt == CW'(WIDTH));
    nx_data[0] = (SH == 0) ? sh_norm : i_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      nx_v[k]    = st_v[k-1];
      nx_user[k] = st_user[k-1];
      nx_cnt[k]  = st_cnt[k-1];
      nx_all[k]  = st_all[k-1];
      nx_data[k] = (k == SH) ? sh_norm : st_data[k-1];
    end
  end

  // Advance the pipeline. The payload is written only for valid beats, so a
  // bubble does not disturb the registers.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      st_v   <= '0;
      st_all <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_data[k] <= '0;
        st_user[k] <= '0;
        st_cnt[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          st_v[k] <= nx_v[k];
          if (nx_v[k]) begin
            st_data[k] <= nx_data[k];
            st_user[k] <= nx_user[k];
            st_cnt[k]  <= nx_cnt[k];
            st_all[k]  <= nx_all[k];
          end
        end
      end
    end
  end

  assign o_valid = st_v[STAGES-1];
  assign o_all   = st_all[STAGES-1];
  assign o_cnt   = st_cnt[STAGES-1];
  assign o_norm  = st_data[STAGES-1];
  assign o_user  = st_user[STAGES-1];

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed bench for lzc_norm_pipe. There are three instances:
// A is 8 bits wide with 2 stages, B is 8 bits wide with 3 stages and a stalling
// stream, and C is 5 bits wide with 1 stage.
module tb_lzc_norm_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstf;

  logic       a_iv, a_ir, a_ov, a_or, a_all;
  logic [7:0] a_id, a_norm;
  logic [1:0] a_im;
  logic [3:0] a_iu, a_ou, a_cnt;

  logic       b_iv, b_ir, b_ov, b_or, b_all;
  logic [7:0] b_id, b_norm;
  logic [1:0] b_im;
  logic [3:0] b_iu, b_ou, b_cnt;

  logic       c_iv, c_ir, c_ov, c_or, c_all;
  logic [4:0] c_id, c_norm;
  logic [1:0] c_im;
  logic [3:0] c_iu, c_ou, c_cnt;

  lzc_norm_pipe #(.WIDTH(8), .STAGES(2), .USER_W(4)) u_a (
    .clk(clk), .rstf(rstf), .i_valid(a_iv), .i_ready(a_ir), .i_data(a_id),
    .i_mode(a_im), .i_user(a_iu), .o_valid(a_ov), .o_ready(a_or),
    .o_cnt(a_cnt), .o_all(a_all), .o_norm(a_norm), .o_user(a_ou)
  );

  lzc_norm_pipe #(.WIDTH(8), .STAGES(3), .USER_W(4)) u_b (
    .clk(clk), .rstf(rstf), .i_valid(b_iv), .i_ready(b_ir), .i_data(b_id),
    .i_mode(b_im), .i_user(b_iu), .o_valid(b_ov), .o_ready(b_or),
    .o_cnt(b_cnt), .o_all(b_all), .o_norm(b_norm), .o_user(b_ou)
  );

  lzc_norm_pipe #(.WIDTH(5), .STAGES(1), .USER_W(4)) u_c (
    .clk(clk), .rstf(rstf), .i_valid(c_iv), .i_ready(c_ir), .i_data(c_id),
    .i_mode(c_im), .i_user(c_iu), .o_valid(c_ov), .o_ready(c_or),
    .o_cnt(c_cnt), .o_all(c_all), .o_norm(c_norm), .o_user(c_ou)
  );

  // Hand-computed vectors for A (8 bits): data, mode, count, all, norm.
  int unsigned ta_d [8] = '{'h10, 'h00, 'hFF, 'hE8, 'hE8, 'h80, 'h01, 'h7F};
  int unsigned ta_m [8] = '{0,     0,     3,     1,     2,     0,     3,     1};
  int unsigned ta_c [8] = '{3,     8,     8,     3,     3,     0,     1,     0};
  int unsigned ta_a [8] = '{0,     1,     1,     0,     0,     0,     0,     0};
  int unsigned ta_n [8] = '{'h80, 'h00, 'h00, 'h40, 'h1D, 'h80, 'h00, 'h7F};

  // Hand-computed vectors for C (5 bits).
  int unsigned tc_d [5] = '{'h01, 'h00, 'h16, 'h1F, 'h0F};
  int unsigned tc_m [5] = '{0,     0,     2,     1,     3};
  int unsigned tc_c [5] = '{4,     5,     1,     5,     4};
  int unsigned tc_a [5] = '{0,     1,     0,     1,     0};
  int unsigned tc_n [5] = '{'h10, 'h00, 'h0B, 'h00, 'h00};

  // Hand-computed 20-beat stream for B (8 bits).
  int unsigned tb_d [20] = '{'h01, 'h3C, 'hC0, 'h0F, 'h55, 'hFF, 'h00, 'h80, 'hA7, 'h12,
                             'hF3, 'h60, 'h00, 'hFF, 'h08, 'hFE, 'hFE, 'h41, 'h3F, 'hB0};
  int unsigned tb_m [20] = '{0, 2, 1, 3, 0, 1, 2, 2, 3, 0, 1, 2, 3, 0, 0, 3, 1, 2, 3, 0};
  int unsigned tb_c [20] = '{7, 2, 2, 4, 1, 8, 8, 7, 3, 3, 4, 5, 0, 0, 4, 0, 7, 0, 6, 0};
  int unsigned tb_a [20] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int unsigned tb_n [20] = '{'h80, 'h0F, 'h00, 'h00, 'hAA, 'h00, 'h00, 'h01, 'h14, 'h90,
                             'h30, 'h03, 'h00, 'hFF, 'h80, 'hFE, 'h00, 'h41, 'h00, 'hB0};

  logic [39:0] rdy_pat = 40'hF3B65C9DE0;
  logic [39:0] vld_pat = 40'hFFF7EFBFFF;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned sent, got, inflight;
  int unsigned j;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rstf = 1'b0;
    a_iv = 1'b0; a_id = '0; a_im = '0; a_iu = '0; a_or = 1'b1;
    b_iv = 1'b0; b_id = '0; b_im = '0; b_iu = '0; b_or = 1'b1;
    c_iv = 1'b0; c_id = '0; c_im = '0; c_iu = '0; c_or = 1'b1;

    // Values held while in reset.
    repeat (2) @(negedge clk);
    check("rst_a_valid", 32'(a_ov), 0);
    check("rst_a_cnt",   32'(a_cnt), 0);
    check("rst_a_all",   32'(a_all), 0);
    check("rst_a_norm",  32'(a_norm), 0);
    check("rst_a_user",  32'(a_ou), 0);
    check("rst_a_ready", 32'(a_ir), 1);
    check("rst_b_valid", 32'(b_ov), 0);
    check("rst_c_valid", 32'(c_ov), 0);
    rstf = 1'b1;

    // A: back-to-back beats, two-cycle latency.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        j = k - 2;
        check("a_valid", 32'(a_ov), 1);
        check("a_cnt",   32'(a_cnt), ta_c[j]);
        check("a_all",   32'(a_all), ta_a[j]);
        check("a_norm",  32'(a_norm), ta_n[j]);
        check("a_user",  32'(a_ou), j + 1);
      end else begin
        check("a_latency_valid", 32'(a_ov), 0);
      end
      if (k < 8) begin
        a_iv = 1'b1;
        a_id = 8'(ta_d[k]);
        a_im = 2'(ta_m[k]);
        a_iu = 4'(k + 1);
      end else begin
        a_iv = 1'b0;
      end
      #1 check("a_ready", 32'(a_ir), 1);
    end

    // C: 5-bit width, single stage, one-cycle latency.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 5) begin
        j = k - 1;
        check("c_valid", 32'(c_ov), 1);
        check("c_cnt",   32'(c_cnt), tc_c[j]);
        check("c_all",   32'(c_all), tc_a[j]);
        check("c_norm",  32'(c_norm), tc_n[j]);
        check("c_user",  32'(c_ou), j + 3);
      end else begin
        check("c_idle_valid", 32'(c_ov), 0);
      end
      if (k < 5) begin
        c_iv = 1'b1;
        c_id = 5'(tc_d[k]);
        c_im = 2'(tc_m[k]);
        c_iu = 4'(k + 3);
      end else begin
        c_iv = 1'b0;
      end
    end

    // B: 3-stage stream with input gaps and a toggling o_ready. The head
    // beat is checked on every cycle that o_valid is high, which also covers
    // hold stability while stalled.
    sent = 0; got = 0; inflight = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (got >= 20) break;
      @(negedge clk);
      if (b_ov) begin
        if (got < 20) begin
          check("b_cnt",  32'(b_cnt), tb_c[got]);
          check("b_all",  32'(b_all), tb_a[got]);
          check("b_norm", 32'(b_norm), tb_n[got]);
          check("b_user", 32'(b_ou), got % 16);
        end else begin
          check("b_extra_beat", 32'(b_ov), 0);
        end
      end
      b_or = rdy_pat[cyc % 40];
      if (sent < 20 && vld_pat[cyc % 40]) begin
        b_iv = 1'b1;
        b_id = 8'(tb_d[sent]);
        b_im = 2'(tb_m[sent]);
        b_iu = 4'(sent % 16);
      end else begin
        b_iv = 1'b0;
      end
      #1;
      check("b_ready", 32'(b_ir), 32'(!(inflight == 3 && !b_or)));
      if (b_ov && b_or) got++;
      if (b_iv && b_ir) sent++;
      inflight = sent - got;
    end
    check("b_emitted",  got, 20);
    check("b_accepted", sent, 20);

    // B: fill the pipe while stalled, then pulse reset.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_or = 1'b0;
      b_iv = 1'b1;
      b_id = 8'h01;
      b_im = 2'b00;
      b_iu = 4'd9;
    end
    #1;
    check("full_b_valid", 32'(b_ov), 1);
    check("full_b_ready", 32'(b_ir), 0);
    @(negedge clk);
    b_iv = 1'b0;
    rstf = 1'b0;
    #1;
    check("arst_b_valid", 32'(b_ov), 0);
    check("arst_b_ready", 32'(b_ir), 1);
    check("arst_b_cnt",   32'(b_cnt), 0);
    check("arst_b_norm",  32'(b_norm), 0);
    check("arst_b_user",  32'(b_ou), 0);
    check("arst_b_all",   32'(b_all), 0);
    @(negedge clk);
    rstf = 1'b1;
    b_or = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_b_valid", 32'(b_ov), 0);
    end
    check("post_rst_b_ready", 32'(b_ir), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
